// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// Purpose: PS/2 keyboard receiver; filters the line, frames 11-bit words and tracks the held key.
// Latency: rx_byte/rx_strobe 1 clk after the stop-bit sample event, key_code/key_valid 1 clk later.
// Backpressure: none; the keyboard cannot be stalled, so every output is a pulse or a held value.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchronizer flops; both lines idle high on the bus.
  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  // Glitch filter on the synchronized clock.
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          sample_evt;

  // Frame receiver state.
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          rx_load;
  logic          err_d;

  // Scan-code prefix tracking.
  logic       ext_q;
  logic       brk_q;
  logic [7:0] code;

  // Two-flop synchronizers for the asynchronous keyboard lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered clock follows the synchronized clock only after FILTER_LEN
  // consecutive samples of the new level; any return to the old level
  // restarts the count, so short glitches never reach the framer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // A bit is taken on each falling edge of the filtered clock. The data line
  // has been stable for half a PS/2 bit period by then, so the synchronized
  // data is sampled directly without extra alignment.
  assign sample_evt = clk_filt_d & ~clk_filt;

  // Frame receiver registers plus the registered byte/error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      to_cnt_q  <= to_cnt_d;
      rx_strobe <= rx_load;
      frame_err <= err_d;
      if (rx_load) begin
        rx_byte <= shift_q;
      end
    end
  end

  // Next-state logic: start/data/parity/stop sequencing and the inactivity
  // timeout that abandons a frame the keyboard stopped clocking.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_load   = 1'b0;
    err_d     = 1'b0;

    if (state_q == IDLE || sample_evt) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (sample_evt && !dat_s2) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_evt) begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {dat_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (sample_evt) begin
          par_d   = dat_s2;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_evt) begin
          state_d = IDLE;
          // Odd parity: data plus parity bit must hold an odd count of ones.
          if (dat_s2 && (^{shift_q, par_q})) begin
            rx_load = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != IDLE && !sample_evt && to_cnt_q == TW'(TIMEOUT - 1)) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      to_cnt_d = '0;
    end
  end

  assign code = {ext_q, rx_byte[6:0]};

  // Scan-code layer: E0/F0 set prefix flags, other bytes make or break keys.
  // A framing error drops any half-received prefix so it cannot attach to
  // an unrelated later byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_err) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!rx_byte[7]) begin
            if (!brk_q) begin
              key_code  <= code;
              key_valid <= 1'b1;
            end else if (code == key_code) begin
              key_code <= '0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for ps2_key_decoder driving bit-level PS/2 frames.
// Latency: expects rx_strobe then key_code/key_valid one clk later.
// Backpressure: none; frames are driven open-loop at a fixed bit rate.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 600;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_key_decoder #(
    .FILTER_LEN(FILT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_valid(key_valid),
    .rx_byte  (rx_byte),
    .rx_strobe(rx_strobe),
    .frame_err(frame_err)
  );

  // One expected outcome per transmitted frame, in order.
  typedef struct packed {
    logic       err;
    logic [7:0] b;
    logic [7:0] key;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int scnt     = 0;
  int ecnt     = 0;

  // Keyboard-protocol model state, advanced as frames are queued.
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_key = 8'h00;

  // Compare-side state.
  logic [7:0] cur_key = 8'h00;
  logic [7:0] last_rx = 8'h00;
  logic       pending = 1'b0;
  exp_t       pend_e;
  exp_t       cmp_e;
  logic       exp_valid_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Protocol rules: E0 marks extended, F0 marks release, other bytes below
  // 0x80 press or release a key, anything else is ignored; prefixes are
  // consumed by the next non-prefix byte.
  task automatic model_byte(input logic [7:0] b, output logic valid);
    logic [7:0] k;
    valid = 1'b0;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b < 8'h80) begin
        k = {m_ext, b[6:0]};
        if (!m_brk) begin
          m_key = k;
          valid = 1'b1;
        end else if (k == m_key) begin
          m_key = 8'h00;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // One PS/2 bit: data set while clock high, then a low half period.
  // Optional short glitches land well after the filtered edge has settled.
  task automatic ps2_bit(input logic d, input logic glitch);
    ps2_data = d;
    if (glitch) begin
      cyc(12); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF - 15);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b0;
    if (glitch) begin
      cyc(13); ps2_clk = 1'b1; cyc(3); ps2_clk = 1'b0; cyc(HALF - 16);
    end else begin
      cyc(HALF);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok,
                            input logic stop_b, input logic glitch);
    exp_t e;
    logic p;
    logic v;
    p = par_ok ? ~(^b) : (^b);
    if (par_ok && stop_b) begin
      model_byte(b, v);
      e.err = 1'b0; e.b = b; e.key = m_key; e.valid = v;
    end else begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      e.err = 1'b1; e.b = b; e.key = m_key; e.valid = 1'b0;
    end
    exp_q.push_back(e);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(stop_b, glitch);
    ps2_data = 1'b1;
    cyc(60);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, 1'b0);
  endtask

  // Per-cycle compare against the model's queued outcomes.
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_key_code", 32'(key_code), 32'h0);
      chk("rst_key_valid", 32'(key_valid), 32'h0);
      chk("rst_rx_byte", 32'(rx_byte), 32'h0);
      chk("rst_rx_strobe", 32'(rx_strobe), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
      cur_key = 8'h00;
      last_rx = 8'h00;
      pending = 1'b0;
    end else begin
      exp_valid_now = 1'b0;
      if (pending) begin
        cur_key       = pend_e.key;
        exp_valid_now = pend_e.valid;
        pending       = 1'b0;
      end
      chk("key_valid", 32'(key_valid), 32'(exp_valid_now));
      chk("key_code", 32'(key_code), 32'(cur_key));
      if (key_valid) vcnt++;
      if (rx_strobe) begin
        scnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(rx_strobe), 32'h0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("strobe_vs_err", 32'(cmp_e.err), 32'h0);
          chk("rx_byte", 32'(rx_byte), 32'(cmp_e.b));
          last_rx = cmp_e.b;
          pend_e  = cmp_e;
          pending = 1'b1;
        end
      end else begin
        chk("rx_byte_hold", 32'(rx_byte), 32'(last_rx));
      end
      if (frame_err) begin
        ecnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_err", 32'(frame_err), 32'h0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("err_vs_good", 32'(cmp_e.err), 32'h1);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    cyc(5);
    chk("lit_rst_key", 32'(key_code), 32'h00);
    reset = 1'b1;
    cyc(20);

    // Extended make.
    good(8'hE0); good(8'h6B);
    chk("lit_ext_key", 32'(key_code), 32'hEB);
    chk("lit_ext_vcnt", 32'(vcnt), 32'd1);
    chk("lit_ext_scnt", 32'(scnt), 32'd2);

    // Extended break of the held key.
    good(8'hE0); good(8'hF0); good(8'h6B);
    chk("lit_brk_key", 32'(key_code), 32'h00);
    chk("lit_brk_vcnt", 32'(vcnt), 32'd1);

    // Bad parity then a good retry.
    send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
    chk("lit_par_err", 32'(ecnt), 32'd1);
    chk("lit_par_rx", 32'(rx_byte), 32'h6B);
    chk("lit_par_key", 32'(key_code), 32'h00);
    good(8'h1D);
    chk("lit_1d_key", 32'(key_code), 32'h1D);
    chk("lit_1d_vcnt", 32'(vcnt), 32'd2);

    // Truncated frame abandoned by the timeout.
    cmp_e.err = 1'b1; cmp_e.b = 8'h00; cmp_e.key = m_key; cmp_e.valid = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    exp_q.push_back(cmp_e);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1), 1'b0);
    ps2_data = 1'b1;
    cyc(TMO + 10);
    chk("lit_tmo_err", 32'(ecnt), 32'd2);
    good(8'h75);
    chk("lit_75_key", 32'(key_code), 32'h75);
    chk("lit_75_vcnt", 32'(vcnt), 32'd3);

    // Glitchy clock.
    send_frame(8'h72, 1'b1, 1'b1, 1'b1);
    chk("lit_glitch_key", 32'(key_code), 32'h72);
    chk("lit_glitch_rx", 32'(rx_byte), 32'h72);
    chk("lit_glitch_vcnt", 32'(vcnt), 32'd4);

    // Typematic repeats then a non-matching break.
    good(8'h74); good(8'h74); good(8'h74);
    chk("lit_rep_vcnt", 32'(vcnt), 32'd7);
    good(8'hF0); good(8'h6B);
    chk("lit_rep_key", 32'(key_code), 32'h74);
    chk("lit_rep_vcnt2", 32'(vcnt), 32'd7);

    // Discarded high byte consumes the E0 prefix.
    good(8'hE0); good(8'h83); good(8'h21);
    chk("lit_disc_key", 32'(key_code), 32'h21);
    chk("lit_disc_vcnt", 32'(vcnt), 32'd8);

    // Stop bit of zero.
    send_frame(8'h2A, 1'b1, 1'b0, 1'b0);
    chk("lit_stop_err", 32'(ecnt), 32'd3);
    chk("lit_stop_rx", 32'(rx_byte), 32'h21);
    chk("lit_stop_key", 32'(key_code), 32'h21);

    // Error after E0 drops the prefix.
    good(8'hE0);
    send_frame(8'h10, 1'b0, 1'b1, 1'b0);
    good(8'h10);
    chk("lit_pfx_err", 32'(ecnt), 32'd4);
    chk("lit_pfx_key", 32'(key_code), 32'h10);

    // Reset mid-frame, then a clean frame.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
    reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_key = 8'h00;
    cyc(5);
    chk("lit_mid_rst_key", 32'(key_code), 32'h00);
    chk("lit_mid_rst_rx", 32'(rx_byte), 32'h00);
    ps2_data = 1'b1;
    reset = 1'b1;
    cyc(20);
    good(8'h75);
    chk("lit_post_rst_key", 32'(key_code), 32'h75);
    chk("lit_post_rst_vcnt", 32'(vcnt), 32'd10);

    cyc(20);
    chk("lit_total_strobes", 32'(scnt), 32'd19);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
